// File: rtl/bbox_scan.sv
// Serial box loader + raster pixel scanner: W-cycle MSB-first load, 1-cycle bounds check, first pixel after edge W+1.
// Backpressure: PX/PY hold until PVALID&PREADY; one pixel per accepted cycle, DONE pulses after the final handshake.
module bbox_scan #(
   parameter int W = 9
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         LOAD,
   input  logic         XMINI,
   input  logic         XMAXI,
   input  logic         YMINI,
   input  logic         YMAXI,
   input  logic         PREADY,
   output logic [W-1:0] PX,
   output logic [W-1:0] PY,
   output logic         PVALID,
   output logic         LAST,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, SCAN} state_t;

   state_t         r_state;
   logic [W-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
   logic [W-1:0]   r_px, r_py;
   logic [CW-1:0]  r_bitcnt;
   logic           r_pvalid, r_done, r_err;
   logic           w_x_end, w_y_end;

   assign w_x_end = (r_px == r_xmax);
   assign w_y_end = (r_py == r_ymax);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= IDLE;
         r_xmin   <= '0;
         r_xmax   <= '0;
         r_ymin   <= '0;
         r_ymax   <= '0;
         r_px     <= '0;
         r_py     <= '0;
         r_bitcnt <= '0;
         r_pvalid <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (LOAD) begin
                  r_xmin   <= {r_xmin[W-2:0], XMINI};
                  r_xmax   <= {r_xmax[W-2:0], XMAXI};
                  r_ymin   <= {r_ymin[W-2:0], YMINI};
                  r_ymax   <= {r_ymax[W-2:0], YMAXI};
                  r_bitcnt <= CW'(1);
                  r_err    <= 1'b0;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (LOAD) begin
                  r_xmin   <= {r_xmin[W-2:0], XMINI};
                  r_xmax   <= {r_xmax[W-2:0], XMAXI};
                  r_ymin   <= {r_ymin[W-2:0], YMINI};
                  r_ymax   <= {r_ymax[W-2:0], YMAXI};
                  r_bitcnt <= r_bitcnt + CW'(1);
                  // this edge shifts the final bit, so the bounds are complete next cycle
                  if (r_bitcnt == CW'(W - 1))
                     r_state <= CHECK;
               end else begin
                  r_state <= IDLE;
               end
            end
            CHECK: begin
               if ((r_xmin > r_xmax) || (r_ymin > r_ymax)) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_px     <= r_xmin;
                  r_py     <= r_ymin;
                  r_pvalid <= 1'b1;
                  r_state  <= SCAN;
               end
            end
            SCAN: begin
               if (PREADY) begin
                  // compare before incrementing so XMAX = 2^W-1 never wraps
                  if (!w_x_end) begin
                     r_px <= r_px + 1'b1;
                  end else if (!w_y_end) begin
                     r_px <= r_xmin;
                     r_py <= r_py + 1'b1;
                  end else begin
                     r_pvalid <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign PX     = r_px;
   assign PY     = r_py;
   assign PVALID = r_pvalid;
   assign LAST   = r_pvalid & w_x_end & w_y_end;
   assign BUSY   = (r_state != IDLE);
   assign DONE   = r_done;
   assign ERR    = r_err;

endmodule

// File: tb/tb_bbox_scan.sv
// Directed bench for bbox_scan: serial box loads, raster scans with and without backpressure, error/abort/reset cases.
module tb_bbox_scan;
   localparam int W = 9;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b1;
   logic         LOAD = 1'b0;
   logic         XMINI = 1'b0, XMAXI = 1'b0, YMINI = 1'b0, YMAXI = 1'b0;
   logic         PREADY = 1'b0;
   logic [W-1:0] PX, PY;
   logic         PVALID, LAST, BUSY, DONE, ERR;

   int total = 0;
   int bad   = 0;

   bbox_scan #(.W(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD),
      .XMINI(XMINI), .XMAXI(XMAXI), .YMINI(YMINI), .YMAXI(YMAXI),
      .PREADY(PREADY), .PX(PX), .PY(PY), .PVALID(PVALID),
      .LAST(LAST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // W edges of serial load, then the CHECK edge; returns 1 ns after edge W+1
   task automatic send_frame(input logic [W-1:0] xmn, input logic [W-1:0] xmx,
                             input logic [W-1:0] ymn, input logic [W-1:0] ymx);
      for (int i = W - 1; i >= 0; i--) begin
         LOAD = 1'b1;
         XMINI = xmn[i]; XMAXI = xmx[i]; YMINI = ymn[i]; YMAXI = ymx[i];
         tick();
         if (i == W - 1) begin
            check("busy_start", 32'(BUSY), 32'd1);
            check("err_clr", 32'(ERR), 32'd0);
            check("done_start", 32'(DONE), 32'd0);
         end
      end
      LOAD = 1'b0;
      XMINI = 1'b0; XMAXI = 1'b0; YMINI = 1'b0; YMAXI = 1'b0;
      check("pv_edgeW", 32'(PVALID), 32'd0);
      tick();
   endtask

   task automatic scan_box(input int xmn, input int xmx, input int ymn, input int ymx,
                           input bit toggle);
      PREADY = 1'b1;
      for (int y = ymn; y <= ymx; y++) begin
         for (int x = xmn; x <= xmx; x++) begin
            check("pv", 32'(PVALID), 32'd1);
            check("px", 32'(PX), 32'(x));
            check("py", 32'(PY), 32'(y));
            check("last", 32'(LAST), 32'((x == xmx) && (y == ymx)));
            if (toggle) begin
               PREADY = 1'b0;
               tick();
               check("px_hold", 32'(PX), 32'(x));
               check("py_hold", 32'(PY), 32'(y));
               check("pv_hold", 32'(PVALID), 32'd1);
               PREADY = 1'b1;
            end
            tick();
         end
      end
      check("pv_end", 32'(PVALID), 32'd0);
      check("done", 32'(DONE), 32'd1);
      check("busy_end", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #1 RST_N = 1'b0;
      #1;
      check("rst_pv", 32'(PVALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_px", 32'(PX), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      #10 RST_N = 1'b1;
      tick();
      check("idle_busy", 32'(BUSY), 32'd0);

      // basic box, then a back-to-back frame started in the DONE cycle
      send_frame(9'd3, 9'd5, 9'd10, 9'd11);
      check("pv_lat", 32'(PVALID), 32'd1);
      scan_box(3, 5, 10, 11, 1'b0);
      send_frame(9'd3, 9'd5, 9'd10, 9'd11);
      scan_box(3, 5, 10, 11, 1'b1);
      tick();
      check("done_pulse", 32'(DONE), 32'd0);

      // top-edge single pixel
      send_frame(9'd511, 9'd511, 9'd0, 9'd0);
      scan_box(511, 511, 0, 0, 1'b0);
      tick();

      // inverted X bounds
      PREADY = 1'b1;
      send_frame(9'd7, 9'd2, 9'd0, 9'd0);
      check("err_set", 32'(ERR), 32'd1);
      check("err_pv", 32'(PVALID), 32'd0);
      check("err_busy", 32'(BUSY), 32'd0);
      tick(); tick();
      check("err_sticky", 32'(ERR), 32'd1);
      check("err_pv2", 32'(PVALID), 32'd0);

      // abort after 5 bits, then a full frame
      for (int i = 0; i < 5; i++) begin
         LOAD = 1'b1; XMINI = 1'b1; XMAXI = 1'b1; YMINI = 1'b1; YMAXI = 1'b1;
         tick();
      end
      check("abort_err_clr", 32'(ERR), 32'd0);
      LOAD = 1'b0; XMINI = 1'b0; XMAXI = 1'b0; YMINI = 1'b0; YMAXI = 1'b0;
      tick();
      check("abort_busy", 32'(BUSY), 32'd0);
      check("abort_pv", 32'(PVALID), 32'd0);
      check("abort_err", 32'(ERR), 32'd0);
      tick();
      check("abort_pv2", 32'(PVALID), 32'd0);
      send_frame(9'd0, 9'd1, 9'd0, 9'd0);
      scan_box(0, 1, 0, 0, 1'b0);
      tick();

      // reset mid-scan
      send_frame(9'd0, 9'd3, 9'd0, 9'd3);
      PREADY = 1'b1;
      tick(); tick(); tick();
      check("pre_rst_px", 32'(PX), 32'd3);
      check("pre_rst_pv", 32'(PVALID), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("arst_pv", 32'(PVALID), 32'd0);
      check("arst_px", 32'(PX), 32'd0);
      check("arst_busy", 32'(BUSY), 32'd0);
      check("arst_last", 32'(LAST), 32'd0);
      #2 RST_N = 1'b1;
      tick();
      check("post_rst_busy", 32'(BUSY), 32'd0);
      send_frame(9'd1, 9'd2, 9'd2, 9'd3);
      scan_box(1, 2, 2, 3, 1'b1);
      tick();
      check("final_done", 32'(DONE), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
